// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer
//   Fetch controller for the extended-format decoder. Reads 16-bit halfwords
//   from a variable-latency instruction memory. Per instruction it selects the
//   16-bit standard format or the 32-bit extended format (chosen by the opcode
//   in the first halfword). It presents the result to decode through a
//   valid/ready holding register, and handles branch redirects, including
//   draining a memory read that is already in flight.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   imem_req/addr   halfword read request, held until imem_valid
//   imem_rdata      read data, sampled when imem_valid=1
//   imem_valid      read completion (may coincide with the request cycle)
//   branch_valid    single-cycle redirect pulse
//   branch_target   redirect halfword address
//   instr_valid     holding register occupied
//   instr_ready     decode accepts on instr_valid & instr_ready
//   instruction_16  first halfword
//   instruction_32  {first, second}, or {first, 16'h0} for the 16-bit format
//   use_extended    instruction is the 32-bit format
//   instr_pc        address of the first halfword
module ifetch_sequencer #(
    parameter int unsigned       ADDR_W          = 8,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0,
    parameter logic [15:0]       EXT_OPCODE_MASK = 16'h00C0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instruction_16,
    output logic [31:0]       instruction_32,
    output logic              use_extended,
    output logic [ADDR_W-1:0] instr_pc
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH1,
        S_FETCH2,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [15:0]       hw1_q, hw1_d;
    logic [15:0]       hw2_q, hw2_d;
    logic              ext_q, ext_d;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_plus2;

    // Modulo-2^ADDR_W arithmetic: the top halfword wraps to address 0.
    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign pc_plus2 = pc_q + ADDR_W'(2);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            hw1_q        <= '0;
            hw2_q        <= '0;
            ext_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hw1_q        <= hw1_d;
            hw2_q        <= hw2_d;
            ext_q        <= ext_d;
        end
    end

    // Next-state logic. A branch beats every other transition. If the
    // outstanding read has not yet returned, its address is kept in
    // drain_addr so that the request stays stable until the memory answers.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hw1_d        = hw1_q;
        hw2_d        = hw2_q;
        ext_d        = ext_q;

        case (state_q)
            S_RESET: state_d = S_FETCH1;

            S_FETCH1: begin
                if (branch_valid) begin
                    pc_d         = branch_target;
                    drain_addr_d = pc_q;
                    state_d      = imem_valid ? S_FETCH1 : S_DRAIN;
                end else if (imem_valid) begin
                    hw1_d   = imem_rdata;
                    ext_d   = EXT_OPCODE_MASK[imem_rdata[15:12]];
                    state_d = EXT_OPCODE_MASK[imem_rdata[15:12]] ? S_FETCH2 : S_HOLD;
                end
            end

            S_FETCH2: begin
                if (branch_valid) begin
                    pc_d         = branch_target;
                    drain_addr_d = pc_plus1;
                    state_d      = imem_valid ? S_FETCH1 : S_DRAIN;
                end else if (imem_valid) begin
                    hw2_d   = imem_rdata;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (instr_ready) begin
                    // The handshake completes even when a branch arrives in
                    // the same cycle; only the next fetch address changes.
                    pc_d    = branch_valid ? branch_target : (ext_q ? pc_plus2 : pc_plus1);
                    state_d = S_FETCH1;
                end else if (branch_valid) begin
                    pc_d    = branch_target;
                    state_d = S_FETCH1;
                end
            end

            S_DRAIN: begin
                if (branch_valid) begin
                    pc_d = branch_target;
                end
                if (imem_valid) begin
                    state_d = S_FETCH1;
                end
            end

            default: state_d = S_RESET;
        endcase
    end

    // Output logic. The data outputs are gated by the hold state, so they
    // read zero whenever no instruction is held, including during reset.
    always_comb begin
        imem_req       = 1'b0;
        imem_addr      = '0;
        instr_valid    = 1'b0;
        use_extended   = 1'b0;
        instruction_16 = '0;
        instruction_32 = '0;
        instr_pc       = '0;

        case (state_q)
            S_FETCH1: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
            end
            S_FETCH2: begin
                imem_req  = 1'b1;
                imem_addr = pc_plus1;
            end
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
            end
            S_HOLD: begin
                instr_valid    = 1'b1;
                use_extended   = ext_q;
                instruction_16 = hw1_q;
                instruction_32 = ext_q ? {hw1_q, hw2_q} : {hw1_q, 16'h0000};
                instr_pc       = pc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ifetch_sequencer.sv
module tb_ifetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        branch_valid = 1'b0;
    logic [7:0]  branch_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instruction_16;
    logic [31:0] instruction_32;
    logic        use_extended;
    logic [7:0]  instr_pc;

    int n_assert = 0;
    int n_fail   = 0;
    int delivered = 0;
    int d_snap;

    // Memory model: answers after mem_wait cycles of a held request.
    logic [15:0] mem [256];
    int unsigned mem_wait = 0;
    int unsigned wait_cnt = 0;

    assign imem_valid = imem_req && (wait_cnt >= mem_wait);
    assign imem_rdata = mem[imem_addr];

    always @(posedge clk) begin
        if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
        if (instr_valid && instr_ready) delivered <= delivered + 1;
    end

    always #5 clk = ~clk;

    ifetch_sequencer #(
        .ADDR_W(8),
        .RESET_PC(8'h00),
        .EXT_OPCODE_MASK(16'h00C0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruction_16(instruction_16),
        .instruction_32(instruction_32),
        .use_extended(use_extended),
        .instr_pc(instr_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (instr_valid !== 1'b1 && i < 40) begin
            @(negedge clk);
            i++;
        end
        check(tag, {31'b0, instr_valid}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1234;
        mem[8'h01] = 16'h6A01;
        mem[8'h02] = 16'hBEEF;
        mem[8'h03] = 16'h2222;
        mem[8'h04] = 16'h3333;
        mem[8'h05] = 16'h5555;
        mem[8'h40] = 16'h4444;
        mem[8'h41] = 16'h1111;
        mem[8'hFF] = 16'h7ABC;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",   {31'b0, imem_req}, 32'd0);
        check("rst_addr",  {24'b0, imem_addr}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_i16",   {16'b0, instruction_16}, 32'd0);
        check("rst_i32",   instruction_32, 32'd0);
        check("rst_ext",   {31'b0, use_extended}, 32'd0);
        check("rst_pc",    {24'b0, instr_pc}, 32'd0);

        // Release reset, zero-wait 16-bit fetch
        rst = 1'b0;
        @(negedge clk);
        check("f1_req",  {31'b0, imem_req}, 32'd1);
        check("f1_addr", {24'b0, imem_addr}, 32'd0);
        @(negedge clk);
        check("i0_valid", {31'b0, instr_valid}, 32'd1);
        check("i0_i16",   {16'b0, instruction_16}, 32'h1234);
        check("i0_i32",   instruction_32, 32'h12340000);
        check("i0_ext",   {31'b0, use_extended}, 32'd0);
        check("i0_pc",    {24'b0, instr_pc}, 32'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        check("i1_addr1", {24'b0, imem_addr}, 32'd1);

        // Extended instruction at 1
        @(negedge clk);
        check("i1_addr2", {24'b0, imem_addr}, 32'd2);
        @(negedge clk);
        check("i1_valid", {31'b0, instr_valid}, 32'd1);
        check("i1_ext",   {31'b0, use_extended}, 32'd1);
        check("i1_i32",   instruction_32, 32'h6A01BEEF);
        check("i1_pc",    {24'b0, instr_pc}, 32'd1);
        @(negedge clk);
        check("i2_addr", {24'b0, imem_addr}, 32'd3);

        // Wait states plus decode back-pressure
        mem_wait = 3;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ws_addr",  {24'b0, imem_addr}, 32'd3);
            check("ws_req",   {31'b0, imem_req}, 32'd1);
            check("ws_valid", {31'b0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, instr_valid}, 32'd1);
            check("bp_i16",   {16'b0, instruction_16}, 32'h2222);
            check("bp_i32",   instruction_32, 32'h22220000);
            check("bp_pc",    {24'b0, instr_pc}, 32'd3);
            @(negedge clk);
        end
        d_snap = delivered;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("bp_once",    delivered, d_snap + 1);
        check("bp_dropped", {31'b0, instr_valid}, 32'd0);

        // Branch during the second wait cycle of the fetch at address 5
        instr_ready = 1'b1;
        begin
            int i = 0;
            while (!(imem_req === 1'b1 && imem_addr === 8'h05 && wait_cnt == 1) && i < 40) begin
                @(negedge clk);
                i++;
            end
        end
        check("br_reach", {24'b0, imem_addr}, 32'h05);
        branch_valid  = 1'b1;
        branch_target = 8'h40;
        @(negedge clk);
        branch_valid = 1'b0;
        check("dr_req",   {31'b0, imem_req}, 32'd1);
        check("dr_addr1", {24'b0, imem_addr}, 32'h05);
        @(negedge clk);
        check("dr_addr2", {24'b0, imem_addr}, 32'h05);
        @(negedge clk);
        check("br_addr", {24'b0, imem_addr}, 32'h40);
        mem_wait = 0;
        wait_valid("br_wait");
        check("br_pc",  {24'b0, instr_pc}, 32'h40);
        check("br_i16", {16'b0, instruction_16}, 32'h4444);
        @(negedge clk);
        instr_ready = 1'b0;

        // Branch coincident with a completed handshake
        wait_valid("co_wait");
        check("co_pc", {24'b0, instr_pc}, 32'h41);
        d_snap = delivered;
        instr_ready   = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 8'hFF;
        @(negedge clk);
        instr_ready  = 1'b0;
        branch_valid = 1'b0;
        check("co_once",  delivered, d_snap + 1);
        check("co_valid", {31'b0, instr_valid}, 32'd0);
        check("co_addr",  {24'b0, imem_addr}, 32'hFF);

        // Extended instruction at the top address wraps to 0
        @(negedge clk);
        check("wr_addr2", {24'b0, imem_addr}, 32'h00);
        @(negedge clk);
        check("wr_valid", {31'b0, instr_valid}, 32'd1);
        check("wr_pc",    {24'b0, instr_pc}, 32'hFF);
        check("wr_i32",   instruction_32, 32'h7ABC1234);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("wr_next", {24'b0, imem_addr}, 32'h01);

        // Asynchronous reset during the second-halfword fetch
        @(negedge clk);
        check("ar_f2", {24'b0, imem_addr}, 32'h02);
        #2 rst = 1'b1;
        #1;
        check("ar_req",  {31'b0, imem_req}, 32'd0);
        check("ar_addr", {24'b0, imem_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ar_restart", {24'b0, imem_addr}, 32'h00);
        wait_valid("ar_wait");
        check("ar_pc",  {24'b0, instr_pc}, 32'h00);
        check("ar_i16", {16'b0, instruction_16}, 32'h1234);

        // Branch while holding without ready: instruction dropped
        d_snap = delivered;
        branch_valid  = 1'b1;
        branch_target = 8'h40;
        @(negedge clk);
        branch_valid = 1'b0;
        check("dp_valid", {31'b0, instr_valid}, 32'd0);
        check("dp_none",  delivered, d_snap);
        check("dp_addr",  {24'b0, imem_addr}, 32'h40);
        wait_valid("dp_wait");
        check("dp_pc", {24'b0, instr_pc}, 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
